pcg_stream_gen: RTL and testbench

- Parametrised PCG-XSH-RR pseudo-random generator with runtime seeding, warm-up discard and a valid/ready output stream.
- Successor to the fixed 16-bit/8-bit free-running PCG in the VGA demoscene tops.
- Feeds dither/noise overlays on the 2-bit RGB TinyVGA path. Output stalls losslessly under backpressure; no values are skipped.

---
 rtl/pcg_pkg.sv | 26 ++
 rtl/pcg_xsh_rr.sv | 22 ++
 rtl/pcg_stream_gen.sv | 119 +++++++++++
 tb/tb_pcg_stream_gen.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcg_pkg.sv
// Shared definitions for the PCG noise blocks: FSM encoding, default LCG
// constants and the width-generic LCG step.
package pcg_pkg;

  typedef enum logic [1:0] {
    PCG_SEED_A = 2'd0,
    PCG_SEED_B = 2'd1,
    PCG_WARM   = 2'd2,
    PCG_RUN    = 2'd3
  } pcg_state_e;

  localparam logic [15:0] PCG_MULT_DEFAULT = 16'h5851;
  localparam logic [15:0] PCG_INC_DEFAULT  = 16'h1405;
  localparam int          PCG_MAX_W        = 64;

  // Computed at the widest supported width; callers truncate to their own
  // STATE_W, which is exact because low product bits only depend on low bits.
  function automatic logic [PCG_MAX_W-1:0] pcg_step(
    input logic [PCG_MAX_W-1:0] s,
    input logic [PCG_MAX_W-1:0] m,
    input logic [PCG_MAX_W-1:0] c
  );
    return s * m + c;
  endfunction

endpackage

// File: rtl/pcg_xsh_rr.sv
// Combinational PCG XSH-RR output permutation of one LCG state.
module pcg_xsh_rr #(
  parameter int STATE_W = 16,
  parameter int OUT_W   = 8
) (
  input  logic [STATE_W-1:0] i_state,
  output logic [OUT_W-1:0]   o_word
);

  localparam int ROT_W  = $clog2(OUT_W);
  localparam int XSHIFT = (ROT_W + OUT_W) / 2;
  localparam int SH     = STATE_W - OUT_W - ROT_W;

  logic [ROT_W-1:0] w_rot;
  logic [OUT_W-1:0] w_x;

  assign w_rot  = i_state[STATE_W-1 -: ROT_W];
  assign w_x    = OUT_W'((i_state ^ (i_state >> XSHIFT)) >> SH);
  // Rotate right: shifting the doubled word brings wrapped bits back in.
  assign o_word = OUT_W'({w_x, w_x} >> w_rot);

endmodule

// File: rtl/pcg_stream_gen.sv
// PCG-XSH-RR generator with runtime seeding, warm-up discard and valid/ready output.
// Optional macro PCG_STREAM_SEL_EN adds stream_id selecting the LCG increment.
module pcg_stream_gen
  import pcg_pkg::*;
#(
  parameter int                 STATE_W      = 16,
  parameter int                 OUT_W        = 8,
  parameter logic [STATE_W-1:0] MULT         = STATE_W'(PCG_MULT_DEFAULT),
  parameter logic [STATE_W-1:0] INC          = STATE_W'(PCG_INC_DEFAULT),
  parameter logic [STATE_W-1:0] SEED_DEFAULT = '0,
  parameter int                 WARMUP       = 0
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef PCG_STREAM_SEL_EN
  input  logic [STATE_W-2:0] stream_id,
`endif
  input  logic               seed_valid,
  input  logic [STATE_W-1:0] seed_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               busy,
  output logic [1:0]         dbg_fsm
);

  localparam logic [1:0] ST_SEED_A = PCG_SEED_A;
  localparam logic [1:0] ST_SEED_B = PCG_SEED_B;
  localparam logic [1:0] ST_WARM   = PCG_WARM;
  localparam logic [1:0] ST_RUN    = PCG_RUN;
  localparam logic [7:0] WARM_LAST = 8'((WARMUP > 0) ? (WARMUP - 1) : 0);

  // Handshake: a word transfers on a clock edge where out_valid and out_ready
  // are both high; out_valid/out_data only change when the slot is empty or
  // being consumed, and a seed load always wins and empties the slot.

  logic [1:0]         r_fsm;
  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] r_seed;
  logic [7:0]         r_warm_cnt;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_data;

  logic [STATE_W-1:0] w_inc;
  logic [STATE_W-1:0] w_step;
  logic [OUT_W-1:0]   w_perm;
  logic               w_adv;

`ifdef PCG_STREAM_SEL_EN
  logic [STATE_W-1:0] r_inc;
  assign w_inc = r_inc;
`else
  assign w_inc = INC;
`endif

  assign w_step = STATE_W'(pcg_step(64'(r_state), 64'(MULT), 64'(w_inc)));
  assign w_adv  = !r_out_valid || out_ready;

  pcg_xsh_rr #(
    .STATE_W (STATE_W),
    .OUT_W   (OUT_W)
  ) u_perm (
    .i_state (r_state),
    .o_word  (w_perm)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm       <= ST_SEED_A;
      r_state     <= '0;
      r_seed      <= SEED_DEFAULT;
      r_warm_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
`ifdef PCG_STREAM_SEL_EN
      r_inc       <= {stream_id, 1'b1};
`endif
    end else if (seed_valid) begin
      r_fsm       <= ST_SEED_A;
      r_seed      <= seed_data;
      r_warm_cnt  <= '0;
      r_out_valid <= 1'b0;
`ifdef PCG_STREAM_SEL_EN
      r_inc       <= {stream_id, 1'b1};
`endif
    end else begin
      case (r_fsm)
        ST_SEED_A: begin
          r_state <= w_inc + r_seed;
          r_fsm   <= ST_SEED_B;
        end
        ST_SEED_B: begin
          r_state    <= w_step;
          r_warm_cnt <= '0;
          r_fsm      <= (WARMUP > 0) ? ST_WARM : ST_RUN;
        end
        ST_WARM: begin
          r_state    <= w_step;
          r_warm_cnt <= r_warm_cnt + 8'd1;
          if (r_warm_cnt == WARM_LAST) r_fsm <= ST_RUN;
        end
        ST_RUN: begin
          if (w_adv) begin
            r_out_data  <= w_perm;
            r_out_valid <= 1'b1;
            r_state     <= w_step;
          end
        end
        default: r_fsm <= ST_SEED_A;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_fsm != ST_RUN);
  assign dbg_fsm   = r_fsm;

endmodule

// File: tb/tb_pcg_stream_gen.sv
// Directed bench for pcg_stream_gen: default, WARMUP=4 and 32-bit instances
// share stimulus; each accepted word is checked against a reference model queue.
module tb_pcg_stream_gen;

  localparam int N_FILL = 10100;

  logic        clk;
  logic        rst_n;
  logic        seed_valid;
  logic [15:0] seed_data;
  logic        out_ready;

  logic        out_valid,   out_valid_w,   out_valid_32;
  logic [7:0]  out_data,    out_data_w;
  logic [15:0] out_data_32;
  logic        busy,        busy_w,        busy_32;
  logic [1:0]  dbg_fsm,     dbg_fsm_w,     dbg_fsm_32;

`ifdef PCG_STREAM_SEL_EN
  logic [14:0] stream16;
  logic [30:0] stream32;
`endif

  logic [7:0]  exp_q[$];
  logic [7:0]  exp_w_q[$];
  logic [15:0] exp_32_q[$];

  int          n_checks;
  int          n_errors;
  int          n_acc, n_acc_w, n_acc_32;
  logic        mon_en;
  logic [7:0]  first_word;
  logic [7:0]  e8;
  logic [15:0] e16;

  pcg_stream_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef PCG_STREAM_SEL_EN
    .stream_id  (stream16),
`endif
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .dbg_fsm    (dbg_fsm)
  );

  pcg_stream_gen #(.WARMUP(4)) dut_w (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef PCG_STREAM_SEL_EN
    .stream_id  (stream16),
`endif
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .out_valid  (out_valid_w),
    .out_ready  (out_ready),
    .out_data   (out_data_w),
    .busy       (busy_w),
    .dbg_fsm    (dbg_fsm_w)
  );

  pcg_stream_gen #(
    .STATE_W (32),
    .OUT_W   (16),
    .MULT    (32'h2C9277B5),
    .INC     (32'hAC564B05)
  ) dut_32 (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef PCG_STREAM_SEL_EN
    .stream_id  (stream32),
`endif
    .seed_valid (seed_valid),
    .seed_data  ({16'h0000, seed_data}),
    .out_valid  (out_valid_32),
    .out_ready  (out_ready),
    .out_data   (out_data_32),
    .busy       (busy_32),
    .dbg_fsm    (dbg_fsm_32)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [15:0] m_step16(input logic [15:0] s, input logic [15:0] c);
    return s * 16'h5851 + c;
  endfunction

  function automatic logic [31:0] m_step32(input logic [31:0] s, input logic [31:0] c);
    return s * 32'h2C9277B5 + c;
  endfunction

  function automatic logic [7:0] m_perm16(input logic [15:0] s);
    logic [15:0] t;
    logic [7:0]  x;
    logic [7:0]  o;
    int          r;
    t = s ^ (s >> 5);
    x = t[12:5];
    r = int'(s[15:13]);
    for (int i = 0; i < 8; i++) o[i] = x[(i + r) % 8];
    return o;
  endfunction

  function automatic logic [15:0] m_perm32(input logic [31:0] s);
    logic [31:0] t;
    logic [15:0] x;
    logic [15:0] o;
    int          r;
    t = s ^ (s >> 10);
    x = t[27:12];
    r = int'(s[31:28]);
    for (int i = 0; i < 16; i++) o[i] = x[(i + r) % 16];
    return o;
  endfunction

  task automatic fill(input logic [15:0] seed);
    logic [15:0] s;
    logic [31:0] s32;
    logic [15:0] inc16;
    logic [31:0] inc32;
`ifdef PCG_STREAM_SEL_EN
    inc16 = {stream16, 1'b1};
    inc32 = {stream32, 1'b1};
`else
    inc16 = 16'h1405;
    inc32 = 32'hAC564B05;
`endif
    exp_q.delete();
    exp_w_q.delete();
    exp_32_q.delete();
    n_acc = 0; n_acc_w = 0; n_acc_32 = 0;
    s   = m_step16(inc16 + seed, inc16);
    s32 = m_step32(inc32 + {16'h0000, seed}, inc32);
    for (int k = 0; k < N_FILL; k++) begin
      exp_q.push_back(m_perm16(s));
      if (k >= 4) exp_w_q.push_back(m_perm16(s));
      exp_32_q.push_back(m_perm32(s32));
      s   = m_step16(s, inc16);
      s32 = m_step32(s32, inc32);
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: a word transfers when valid and ready meet at the next edge.
  always @(negedge clk) begin
    if (mon_en && out_ready) begin
      if (out_valid) begin
        e8 = (exp_q.size() != 0) ? exp_q.pop_front() : ~out_data;
        check("word", 64'(out_data), 64'(e8));
        n_acc++;
      end
      if (out_valid_w) begin
        e8 = (exp_w_q.size() != 0) ? exp_w_q.pop_front() : ~out_data_w;
        check("word_w", 64'(out_data_w), 64'(e8));
        n_acc_w++;
      end
      if (out_valid_32) begin
        e16 = (exp_32_q.size() != 0) ? exp_32_q.pop_front() : ~out_data_32;
        check("word_32", 64'(out_data_32), 64'(e16));
        check("x_32", 64'($isunknown(out_data_32)), 64'(0));
        n_acc_32++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_seed(input logic [15:0] s);
    int lat_a;
    int lat_w;
    int nbusy;
    mon_en     = 1'b0;
    seed_valid = 1'b1;
    seed_data  = s;
    step();
    seed_valid = 1'b0;
    check("flush_v",    64'(out_valid),    64'(0));
    check("flush_v_w",  64'(out_valid_w),  64'(0));
    check("flush_v_32", 64'(out_valid_32), 64'(0));
    check("seed_busy",  64'(busy),         64'(1));
    check("seed_fsm_32", 64'(dbg_fsm_32),  64'(0));
    check("seed_busy_32", 64'(busy_32),    64'(1));
    fill(s);
    mon_en    = 1'b1;
    out_ready = 1'b1;
    lat_a = 0;
    lat_w = 0;
    nbusy = busy_w ? 1 : 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (out_valid && lat_a == 0) begin
        lat_a      = i;
        first_word = out_data;
      end
      if (out_valid_w && lat_w == 0) lat_w = i;
      if (busy_w) nbusy++;
    end
    check("latency",       64'(lat_a), 64'(3));
    check("latency_w",     64'(lat_w), 64'(7));
    check("busy_w_cycles", 64'(nbusy), 64'(6));
  endtask

  // ---------------- directed sequence ----------------
`ifdef PCG_STREAM_SEL_EN
  logic [7:0] w3, w5;
`endif

  initial begin
    n_checks = 0; n_errors = 0;
    n_acc = 0; n_acc_w = 0; n_acc_32 = 0;
    first_word = '0; e8 = '0; e16 = '0;
    mon_en     = 1'b0;
    rst_n      = 1'b0;
    seed_valid = 1'b0;
    seed_data  = 16'h0000;
    out_ready  = 1'b1;
`ifdef PCG_STREAM_SEL_EN
    stream16 = 15'h0A02;
    stream32 = 31'h562B2582;
`endif

    repeat (3) step();
    check("rst_valid",   64'(out_valid),   64'(0));
    check("rst_data",    64'(out_data),    64'(0));
    check("rst_busy",    64'(busy),        64'(1));
    check("rst_fsm",     64'(dbg_fsm),     64'(0));
    check("rst_state",   64'(dut.r_state), 64'(0));
    check("rst_valid_w", 64'(out_valid_w), 64'(0));
    check("rst_data_32", 64'(out_data_32), 64'(0));

    rst_n = 1'b1;
    fill(16'h0000);
    mon_en = 1'b1;
    step();
    check("rel1_valid", 64'(out_valid), 64'(0));
    check("rel1_fsm",   64'(dbg_fsm),   64'(1));
    check("rel1_busy",  64'(busy),      64'(1));
    step();
    check("rel2_state", 64'(dut.r_state), 64'(16'h219A));
    check("rel2_valid", 64'(out_valid),   64'(0));
    check("rel2_fsm",   64'(dbg_fsm),     64'(3));
    check("rel2_busy",  64'(busy),        64'(0));
    step();
    check("rel3_valid", 64'(out_valid), 64'(1));
    check("rel3_data",  64'(out_data),  64'(8'h02));

    repeat (1000) step();
    check("acc_1000", 64'(n_acc >= 1000), 64'(1));

    // Mid-stream stall: the presented word must be the next expected one.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_valid",   64'(out_valid),   64'(1));
      check("stall_hold",    64'(out_data),    64'(exp_q[0]));
      check("stall_hold_32", 64'(out_data_32), 64'(exp_32_q[0]));
    end
    out_ready = 1'b1;
    repeat (20) step();

    for (int i = 0; i < 60; i++) begin
      out_ready = (i % 3 != 0);
      step();
    end

    // Reseed while stalled with a word pending.
    out_ready = 1'b0;
    repeat (3) step();
    check("pre_seed_valid", 64'(out_valid), 64'(1));
    do_seed(16'h1234);
    repeat (100) step();

    // Reseed in the middle of dut_w's warm-up.
    mon_en     = 1'b0;
    seed_valid = 1'b1;
    seed_data  = 16'h0042;
    step();
    seed_valid = 1'b0;
    fill(16'h0042);
    mon_en = 1'b1;
    repeat (3) step();
    check("mid_warm_fsm_w", 64'(dbg_fsm_w), 64'(2));
    check("mid_warm_valid", 64'(out_valid), 64'(1));
    do_seed(16'h1234);
    repeat (100) step();

`ifdef PCG_STREAM_SEL_EN
    stream16 = 15'd3;
    do_seed(16'h0001);
    w3 = first_word;
    repeat (50) step();
    stream16 = 15'd5;
    do_seed(16'h0001);
    w5 = first_word;
    repeat (50) step();
    check("stream_diff", 64'(w3 != w5), 64'(1));
    stream16 = 15'h0A02;
`endif

    do_seed(16'hC0DE);
    repeat (10050) step();
    check("acc_32_10000", 64'(n_acc_32 >= 10000), 64'(1));
    check("acc_10000",    64'(n_acc >= 10000),    64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
